// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Upstream fetch stage for the JericallaEvo datapath. Holds a small loadable
//   instruction store and a program counter. It presents each program word on
//   `instruction` for HOLD_CYCLES clocks so the downstream two-stage Buffer
//   pipeline can settle. It also honours stall and parks in HALT at program end.
//
// Ports
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   load_en/addr/data : store write port (accepted in IDLE/HALT only)
//   prog_len        : words to run, latched (clamped to DEPTH) on start
//   start           : begin execution at address 0 (load_en wins if both)
//   stall           : freeze fetch progress while in FETCH
//   instruction     : registered store word for the datapath
//   instr_valid     : instruction is a real program word
//   pc              : address of the word on `instruction`
//   halted          : program completed
//   issued_count    : words fully presented since last start (wraps)
// ---------------------------------------------------------------------------
module instruction_fetch #(
   parameter int DEPTH       = 32,
   parameter int ADDR_W      = 5,
   parameter int HOLD_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [16:0]       load_data,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              start,
   input  logic              stall,
   output logic [16:0]       instruction,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic [7:0]        issued_count
);

   localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

   state_t            state_q, state_n;
   logic [16:0]       mem [DEPTH];
   logic [HC_W-1:0]   hold_q, hold_n;
   logic [ADDR_W:0]   len_q, len_n;
   logic [ADDR_W-1:0] pc_n, pc_inc;
   logic [16:0]       instr_n;
   logic              valid_n, halted_n, last_word;
   logic [7:0]        cnt_n;
   logic [ADDR_W:0]   len_clamp;

   // Store: no reset, writes are only accepted while no program is running so
   // the fetched sequence can never be disturbed mid-run.
   always_ff @(posedge clock) begin
      if (load_en && (state_q != S_FETCH))
         mem[load_addr] <= load_data;
   end

   assign len_clamp = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
   assign pc_inc    = pc + 1'b1;
   assign last_word = ({1'b0, pc} == (len_q - 1'b1));

   always_comb begin
      state_n  = state_q;
      pc_n     = pc;
      instr_n  = instruction;
      valid_n  = instr_valid;
      halted_n = halted;
      cnt_n    = issued_count;
      hold_n   = hold_q;
      len_n    = len_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start && !load_en) begin
               len_n    = len_clamp;
               cnt_n    = 8'd0;
               halted_n = 1'b0;
               if (len_clamp == '0) begin
                  state_n  = S_HALT;
                  halted_n = 1'b1;
                  valid_n  = 1'b0;
                  instr_n  = 17'b0;
               end else begin
                  state_n = S_FETCH;
                  pc_n    = '0;
                  instr_n = mem[0];
                  valid_n = 1'b1;
                  hold_n  = '0;
               end
            end
         end
         S_FETCH: begin
            if (!stall) begin
               if (hold_q != HOLD_LAST) begin
                  hold_n = hold_q + 1'b1;
               end else begin
                  // word fully presented: count it and advance or finish
                  hold_n = '0;
                  cnt_n  = issued_count + 1'b1;
                  if (last_word) begin
                     state_n  = S_HALT;
                     instr_n  = 17'b0;
                     valid_n  = 1'b0;
                     halted_n = 1'b1;
                  end else begin
                     pc_n    = pc_inc;
                     instr_n = mem[pc_inc];
                  end
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pc           <= '0;
         instruction  <= 17'b0;
         instr_valid  <= 1'b0;
         halted       <= 1'b0;
         issued_count <= 8'd0;
         hold_q       <= '0;
         len_q        <= '0;
      end else begin
         state_q      <= state_n;
         pc           <= pc_n;
         instruction  <= instr_n;
         instr_valid  <= valid_n;
         halted       <= halted_n;
         issued_count <= cnt_n;
         hold_q       <= hold_n;
         len_q        <= len_n;
      end
   end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream fetch stage for the JericallaEvo datapath.
- Holds a small loadable instruction store and a program counter.
- Drives the 17-bit `instruction` bus, presenting each word for a fixed number of clock cycles so the two-stage Buffer pipeline can settle.
- Sequences a program of `prog_len` words, supports stall, and stops in a halted state at program end.

Parameters:
- DEPTH, 32: number of 17-bit words in the instruction store.
- ADDR_W, 5: PC / address width; must equal clog2(DEPTH).
- HOLD_CYCLES, 2: cycles each instruction stays on the bus; legal range is 1 or more.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  write `load_data` into the store at `load_addr`.
- load_addr  in  ADDR_W  store write address.
- load_data  in  17  instruction word: {opcode[16:15], wr[14:10], rs1[9:5], rs2[4:0]}.
- prog_len  in  ADDR_W+1  number of words to execute; sampled on start.
- start  in  1  begin execution at address 0.
- stall  in  1  freeze fetch progress.
- instruction  out  17  current instruction to the datapath.
- instr_valid  out  1  `instruction` holds a real program word.
- pc  out  ADDR_W  address of the word on `instruction`.
- halted  out  1  program completed.
- issued_count  out  8  number of instructions fully presented since last start; wraps at 255→0.

Behaviour:
- Reset (async, any state):
  - state=IDLE; pc=0; instruction=17'b0; instr_valid=0; halted=0; issued_count=0; hold counter=0; latched length=0.
  - Store contents are NOT reset.
  - Reset mid-FETCH aborts the program immediately.
- States: IDLE, FETCH, HALT.
- IDLE / HALT:
  - load_en=1 writes the store. Load has priority: start in the same cycle is ignored.
  - start=1 (with load_en=0):
    - len = min(prog_len, DEPTH); issued_count<=0; halted<=0.
    - If len=0: go to HALT with halted<=1.
    - Else: pc<=0, instruction<=mem[0], instr_valid<=1, hold counter<=0, go to FETCH.
    - Latency: word 0 is on the bus one edge after start is sampled.
  - HALT holds instruction=17'b0, instr_valid=0, halted=1 until reset or a new start.
- FETCH:
  - load_en and start are ignored.
  - stall=1: pc, instruction, hold counter and issued_count frozen; instr_valid stays 1.
  - stall=0 and hold counter < HOLD_CYCLES-1: hold counter++.
  - stall=0 and hold counter = HOLD_CYCLES-1: issued_count++ and hold counter<=0. Then:
    - If pc = len-1: go to HALT; instruction<=0, instr_valid<=0, halted<=1; pc stays at len-1.
    - Else: pc<=pc+1, instruction<=mem[pc+1].
- Each word is therefore valid for exactly HOLD_CYCLES + (stalled cycles) clocks.
- Store read data is registered into `instruction`. The word visible at `pc` is always mem[pc] as of the cycle it was fetched; a later write to that address does not alter the bus.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, load mem[0..3] = 00_00100_00000_00001, 01_00101_00001_00010, 10_00110_00010_00011, 11_00000_00111_00100; prog_len=4; start pulse:
  - Each word appears in order for exactly 2 clocks with instr_valid=1 and pc 0,1,2,3.
  - Then halted=1, instr_valid=0, issued_count=4.
- Same program, stall=1 for 3 cycles while pc=1 → word 1 held for 5 clocks; total run 11 cycles; final issued_count=4.
- prog_len=0 with start → halted=1 the next cycle, instr_valid never asserted, issued_count=0.
- prog_len=40, DEPTH=32 → run clamps to 32 words; last pc=31; halted=1.
- Assert reset at pc=2 mid-hold → all outputs return to reset values at once. Then start with prog_len=4 → execution resumes from mem[0] with the original contents.
- Cycle with load_en=1 and start=1 in IDLE → write occurs, no start. Start pulsed again next cycle → fetched word 0 shows the new data.
- load_en during FETCH → store unchanged, bus unaffected.
